gated_logic_pipe: RTL and testbench

//  Parametrised, pipelined successor of the team's 4-input gate cell: per bit, y = ~a & (~(b & c) | d).

---
 rtl/gated_logic_pkg.sv | 22 ++
 rtl/gated_logic_pipe_if.sv | 45 ++++
 rtl/gated_logic_stage.sv | 41 ++++
 rtl/gated_logic_pipe.sv | 96 +++++++++
 tb/tb_gated_logic_pipe.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gated_logic_pkg.sv
// Shared types and helpers for the gated logic pipeline.
// Optional feature macro used by this slice: GLP_PARITY_EN (adds y_par).
package gated_logic_pkg;

    localparam int GLP_WIDTH_DEF = 8;
    localparam int GLP_DEPTH_DEF = 2;
    localparam int GLP_CNT_W_DEF = 16;

    // Widest operand glp_eval handles; callers size-cast in and out.
    localparam int GLP_MAX_W = 64;

    // Bitwise gate function: y = ~a & (~(b & c) | d).
    function automatic logic [GLP_MAX_W-1:0] glp_eval(
        input logic [GLP_MAX_W-1:0] a,
        input logic [GLP_MAX_W-1:0] b,
        input logic [GLP_MAX_W-1:0] c,
        input logic [GLP_MAX_W-1:0] d
    );
        return ~a & (~(b & c) | d);
    endfunction

endpackage

// File: rtl/gated_logic_pipe_if.sv
// Operand/result handshake bundle for gated_logic_pipe.
// Optional feature macro: GLP_PARITY_EN (adds y_par to the result side).
//
// Handshake semantics (both sides): a beat transfers on a rising edge where
// valid & ready are both high. Once valid is raised it, and its payload, stay
// stable until the transfer; ready may be combinational and may depend on
// the downstream ready; valid never depends on ready.
interface gated_logic_pipe_if
    import gated_logic_pkg::*;
#(
    parameter int WIDTH = GLP_WIDTH_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             y_any;
`ifdef GLP_PARITY_EN
    logic             y_par;
`endif

    modport master (
        output in_valid, a, b, c, d, out_ready,
        input  in_ready, out_valid, y, y_any
`ifdef GLP_PARITY_EN
        , input y_par
`endif
    );

    modport slave (
        input  in_valid, a, b, c, d, out_ready,
        output in_ready, out_valid, y, y_any
`ifdef GLP_PARITY_EN
        , output y_par
`endif
    );

endinterface

// File: rtl/gated_logic_stage.sv
// One valid/ready register slice. Accepts a new beat when empty or when its
// current beat leaves in the same cycle, so a chain of slices runs at one
// beat per cycle and holds its data stable while stalled.
module gated_logic_stage
    import gated_logic_pkg::*;
#(
    parameter int DW = GLP_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          full;
    logic [DW-1:0] data;
    logic          load;

    assign in_ready  = ~full | out_ready;
    assign load      = in_valid & in_ready;
    assign out_valid = full;
    assign out_data  = data;

    // Occupancy and payload register; data only changes on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= in_data;
        end else if (out_ready) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/gated_logic_pipe.sv
// Pipelined bitwise gate y = ~a & (~(b & c) | d) over DEPTH valid/ready
// slices, with a saturating count of output beats that have any bit set.
// Optional feature macro: GLP_PARITY_EN (even parity y_par carried with y).
// WIDTH is limited to GLP_MAX_W by the package evaluator.
module gated_logic_pipe
    import gated_logic_pkg::*;
#(
    parameter int WIDTH = GLP_WIDTH_DEF,
    parameter int DEPTH = GLP_DEPTH_DEF,
    parameter int CNT_W = GLP_CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    gated_logic_pipe_if.slave  bus,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   hit_cnt
);

`ifdef GLP_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int DW = WIDTH + PAR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] eval_y;
    logic [DW-1:0]    stage_in;
    logic [DW-1:0]    stage_out;

    // The function is evaluated once, on the incoming operands; later
    // slices only carry the result.
    assign eval_y = WIDTH'(glp_eval(GLP_MAX_W'(bus.a), GLP_MAX_W'(bus.b),
                                    GLP_MAX_W'(bus.c), GLP_MAX_W'(bus.d)));

`ifdef GLP_PARITY_EN
    assign stage_in = {^eval_y, eval_y};
`else
    assign stage_in = eval_y;
`endif

    for (genvar k = 0; k < DEPTH; k++) begin : stg
        logic          vin;
        logic          rin;
        logic          vout;
        logic          rout;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;

        if (k == 0) begin : g_head
            assign vin = bus.in_valid;
            assign din = stage_in;
        end else begin : g_link
            assign vin = stg[k-1].vout;
            assign din = stg[k-1].dout;
        end

        if (k == DEPTH - 1) begin : g_tail
            assign rout = bus.out_ready;
        end else begin : g_next
            assign rout = stg[k+1].rin;
        end

        gated_logic_stage #(.DW(DW)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vin),
            .in_ready  (rin),
            .in_data   (din),
            .out_valid (vout),
            .out_ready (rout),
            .out_data  (dout)
        );
    end

    assign bus.in_ready  = stg[0].rin;
    assign bus.out_valid = stg[DEPTH-1].vout;
    assign stage_out     = stg[DEPTH-1].dout;
    assign bus.y         = stage_out[WIDTH-1:0];
    assign bus.y_any     = |stage_out[WIDTH-1:0];
`ifdef GLP_PARITY_EN
    assign bus.y_par     = stage_out[WIDTH];
`endif

    // Saturating hit counter; a clear in the same cycle as a hit wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (cnt_clr) begin
            hit_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready && bus.y_any && (hit_cnt != CNT_MAX)) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gated_logic_pipe.sv
// Directed bench for gated_logic_pipe at WIDTH=4, DEPTH=2, CNT_W=2.
// Build with GLP_PARITY_EN defined to also cover y_par.
module tb_gated_logic_pipe;

  localparam int W  = 4;
  localparam int D  = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] hit_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit stream_done = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_e;

  gated_logic_pipe_if #(.WIDTH(W)) bus ();

  gated_logic_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .cnt_clr (cnt_clr),
    .hit_cnt (hit_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, b, c, d);
    return ~a & (~(b & c) | d);
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.a, bus.b, bus.c, bus.d));
      if (bus.out_valid && bus.out_ready) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          sb_e = exp_q.pop_front();
          check("sb_y", 32'(bus.y), 32'(sb_e));
          check("sb_any", 32'(bus.y_any), 32'(|sb_e));
`ifdef GLP_PARITY_EN
          check("sb_par", 32'(bus.y_par), 32'(^sb_e));
`endif
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic drive_beat(input logic [W-1:0] ai, bi, ci, di);
    int n = 0;
    bus.a = ai; bus.b = bi; bus.c = ci; bus.d = di;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("in_accept", 32'(bus.in_ready), 32'h1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Returns at the negedge where out_valid is seen.
  task automatic wait_out(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.out_valid), 32'h1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'h0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus tables ----------------
  logic [W-1:0] tt_a[4] = '{4'b1111, 4'b0000, 4'b1010, 4'b0101};
  logic [W-1:0] tt_b[4] = '{4'b1010, 4'b0000, 4'b1111, 4'b0110};
  logic [W-1:0] tt_c[4] = '{4'b0101, 4'b0000, 4'b1111, 4'b0011};
  logic [W-1:0] tt_d[4] = '{4'b1111, 4'b0000, 4'b0100, 4'b0000};
  logic [W-1:0] tt_y[4] = '{4'b0000, 4'b1111, 4'b0100, 4'b1000};

  logic [W-1:0] bp_a[3] = '{4'b0001, 4'b0100, 4'b0000};
  logic [W-1:0] bp_b[3] = '{4'b0011, 4'b1111, 4'b1010};
  logic [W-1:0] bp_c[3] = '{4'b0101, 4'b1111, 4'b1010};
  logic [W-1:0] bp_d[3] = '{4'b0000, 4'b0010, 4'b1000};

  logic [CW-1:0] cnt_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  // ---------------- test sequence ----------------
  initial begin
    int acc;
    int idx;
    int t0;
    int seen;

    bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_y", 32'(bus.y), 32'h0);
    check("rst_y_any", 32'(bus.y_any), 32'h0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'h0);
`ifdef GLP_PARITY_EN
    check("rst_y_par", 32'(bus.y_par), 32'h0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk); #1;

    // Truth table with latency: result visible DEPTH edges after transfer
    drive_beat(4'b0000, 4'b1100, 4'b1010, 4'b0001);
    @(negedge clk);
    check("lat_early", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    check("lat_valid", 32'(bus.out_valid), 32'h1);
    check("tt0_y", 32'(bus.y), 32'h7);
    check("tt0_any", 32'(bus.y_any), 32'h1);
`ifdef GLP_PARITY_EN
    check("tt0_par", 32'(bus.y_par), 32'h1);
`endif
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(tt_a[i], tt_b[i], tt_c[i], tt_d[i]);
      wait_out("tt_seen");
      check("tt_y", 32'(bus.y), 32'(tt_y[i]));
      check("tt_any", 32'(bus.y_any), 32'(tt_y[i] != '0));
      @(posedge clk); #1;
    end

    // Backpressure: only DEPTH beats enter, output holds steady
    bus.out_ready = 1'b0;
    acc = 0;
    idx = 0;
    bus.a = bp_a[0]; bus.b = bp_b[0]; bus.c = bp_c[0]; bus.d = bp_d[0];
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc++;
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 3) begin
        bus.a = bp_a[idx]; bus.b = bp_b[idx]; bus.c = bp_c[idx]; bus.d = bp_d[idx];
      end
    end
    @(negedge clk);
    check("bp_accepted", 32'(acc), 32'(D));
    check("bp_in_ready", 32'(bus.in_ready), 32'h0);
    check("bp_out_valid", 32'(bus.out_valid), 32'h1);
    check("bp_y", 32'(bus.y), 32'he);
    repeat (3) @(negedge clk);
    check("bp_y_hold", 32'(bus.y), 32'he);
    check("bp_valid_hold", 32'(bus.out_valid), 32'h1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive_beat(bp_a[2], bp_b[2], bp_c[2], bp_d[2]);
    drain();

    // Streaming with random downstream stalls
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          drive_beat(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                     W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Full throughput: 8 beats in 8 cycles with out_ready held high
    t0 = cyc;
    for (int i = 0; i < 8; i++)
      drive_beat(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                 W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    check("thru_cycles", 32'(cyc - t0), 32'h8);
    drain();

    // Saturating counter
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("cnt_cleared", 32'(hit_cnt), 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive_beat(4'b0000, 4'b0000, 4'b0000, 4'b0000);
      wait_out("cnt_seen");
      @(negedge clk);
      check("cnt_sat", 32'(hit_cnt), 32'(cnt_exp[i]));
      @(posedge clk); #1;
    end
    drive_beat(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    wait_out("clr_seen");
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("cnt_clr_wins", 32'(hit_cnt), 32'h0);
    @(posedge clk); #1;
    drive_beat(4'b1111, 4'b0000, 4'b0000, 4'b0000);
    wait_out("nohit_seen");
    @(negedge clk);
    check("cnt_no_hit", 32'(hit_cnt), 32'h0);
    @(posedge clk); #1;
    drive_beat(4'b0000, 4'b1100, 4'b1010, 4'b0001);
    wait_out("hit_seen");
    @(negedge clk);
    check("cnt_one", 32'(hit_cnt), 32'h1);
    @(posedge clk); #1;

    // Reset with two beats in flight
    bus.out_ready = 1'b0;
    drive_beat(4'b0000, 4'b0000, 4'b0000, 4'b0001);
    drive_beat(4'b0001, 4'b0011, 4'b0101, 4'b0000);
    @(negedge clk);
    check("pre_rst_in_ready", 32'(bus.in_ready), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'h0);
    check("arst_hit_cnt", 32'(hit_cnt), 32'h0);
    check("arst_y", 32'(bus.y), 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("rst_no_stale", 32'(seen), 32'h0);
    check("rst_cnt_stays", 32'(hit_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
